// File: rtl/mac_driver_if.sv
// Bundle of command, mac-side and result signals for mac_driver.
// master is the driver itself; slave is the controller/mac/consumer side.
interface mac_driver_if #(
  parameter int C_W   = 16,
  parameter int O_W   = 16,
  parameter int CNT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [C_W-1:0]   cmd_data;
  logic [C_W-1:0]   mac_c;
  logic             mac_en;
  logic             mac_finish;
  logic [O_W-1:0]   mac_o;
  logic             res_valid;
  logic             res_ready;
  logic [O_W-1:0]   res_data;
  logic             res_err;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    input  cmd_valid, cmd_data, mac_finish, mac_o, res_ready,
    output cmd_ready, mac_c, mac_en, res_valid, res_data, res_err, busy, err_cnt
  );

  modport slave (
    output cmd_valid, cmd_data, mac_finish, mac_o, res_ready,
    input  cmd_ready, mac_c, mac_en, res_valid, res_data, res_err, busy, err_cnt
  );
endinterface

// File: rtl/mac_driver.sv
// Initiator-side sequencer for the mac block: launches one operand at a time,
// waits for finish or timeout, and queues results in a small FIFO.
module mac_driver #(
  parameter int C_W     = 16,
  parameter int O_W     = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  mac_driver_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t           r_state;
  logic [C_W-1:0]   r_mac_c;
  logic             r_mac_en;
  logic             r_cmd_ready;
  logic             r_busy;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [O_W:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_timeout;
  logic             w_push;
  logic             w_push_err;
  logic [O_W-1:0]   w_push_data;
  logic             w_pop;
  logic             w_accept;
  logic [CW-1:0]    w_count_next;
  logic             w_space_next;
  logic [O_W:0]     w_head;

  always_comb begin
    w_timeout    = (r_wcnt == CNT_W'(TIMEOUT - 1));
    w_push       = (r_state == S_WAIT) && (bus.mac_finish || w_timeout);
    w_push_err   = !bus.mac_finish;
    w_push_data  = bus.mac_finish ? bus.mac_o : '0;
    w_pop        = (r_count != '0) && bus.res_ready;
    w_accept     = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_space_next = (w_count_next < CW'(DEPTH));
    w_head       = r_mem[r_rptr];
  end

  // cmd_ready is registered from the post-edge FIFO count, so it is already
  // valid in the first IDLE cycle after a completion or a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mac_c     <= '0;
      r_mac_en    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_wcnt      <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mac_c     <= bus.cmd_data;
            r_mac_en    <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LAUNCH;
          end else begin
            r_cmd_ready <= w_space_next;
          end
        end
        S_LAUNCH: begin
          r_mac_en <= 1'b0;
          r_wcnt   <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (w_push) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= w_space_next;
            if (w_push_err && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mac_en    <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_push_err, w_push_data};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.mac_c     = r_mac_c;
  assign bus.mac_en    = r_mac_en;
  assign bus.busy      = r_busy;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.res_valid = (r_count != '0);
  assign bus.res_data  = (r_count != '0) ? w_head[O_W-1:0] : '0;
  assign bus.res_err   = (r_count != '0) ? w_head[O_W] : 1'b0;

endmodule

// File: tb/tb_mac_driver.sv
// Directed plus randomized bench for mac_driver; a result queue and error
// counter model the expected FIFO contents and timeout statistics.
`timescale 1ns/1ps
module tb_mac_driver;

  localparam int C_W   = 16;
  localparam int O_W   = 16;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct packed {
    logic           err;
    logic [O_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_driver_if #(.C_W(C_W), .O_W(O_W), .CNT_W(CNT_W)) bus ();

  mac_driver #(
    .C_W(C_W), .O_W(O_W), .TIMEOUT(TO), .CNT_W(CNT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t        q[$];
  int unsigned err_m = 0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_valid"}, bus.res_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk({tag, "_data"}, bus.res_data, q[0].data);
      chk({tag, "_err"},  bus.res_err,  q[0].err);
    end else begin
      chk({tag, "_data0"}, bus.res_data, 0);
      chk({tag, "_err0"},  bus.res_err,  0);
    end
    chk({tag, "_errcnt"}, bus.err_cnt, err_m);
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk({tag, "_rdy_after"}, bus.cmd_ready, q.size() < DEPTH);
  endtask

  // fin_at: WAIT-cycle index (0 = first WAIT cycle) carrying mac_finish;
  // any value outside 0..TO-1 means the mac never answers.
  task automatic run_op(input logic [C_W-1:0] d, input int fin_at, input logic [O_W-1:0] o,
                        input bit stray_launch, input bit pop_at_push);
    int   n;
    int   k_end;
    bit   to;
    ent_t e;
    chk("cmd_ready_pre", bus.cmd_ready, q.size() < DEPTH);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.mac_en !== 1'b1 && n < 20);
    chk("accept_lat", n, 1);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = C_W'($urandom);
    chk("launch_en", bus.mac_en, 1);
    chk("launch_busy", bus.busy, 1);
    chk("launch_rdy", bus.cmd_ready, 0);
    chk("launch_c", bus.mac_c, d);
    if (stray_launch) begin
      bus.mac_finish = 1'b1;
      bus.mac_o      = O_W'($urandom);
    end
    step();
    bus.mac_finish = 1'b0;
    to    = !(fin_at >= 0 && fin_at < TO);
    k_end = to ? TO - 1 : fin_at;
    for (int k = 0; k <= k_end; k++) begin
      chk("wait_en", bus.mac_en, 0);
      chk("wait_busy", bus.busy, 1);
      chk("wait_c", bus.mac_c, d);
      chk("wait_rdy", bus.cmd_ready, 0);
      if (k == fin_at) begin
        bus.mac_finish = 1'b1;
        bus.mac_o      = o;
      end
      if (k == k_end && pop_at_push && q.size() != 0) bus.res_ready = 1'b1;
      step();
      bus.mac_finish = 1'b0;
      bus.mac_o      = O_W'($urandom);
      if (bus.res_ready) begin
        void'(q.pop_front());
        bus.res_ready = 1'b0;
      end
    end
    e.err  = to;
    e.data = to ? '0 : o;
    q.push_back(e);
    if (to && err_m < (1 << CNT_W) - 1) err_m++;
    chk("done_busy", bus.busy, 0);
    chk("done_en", bus.mac_en, 0);
    chk("done_rdy", bus.cmd_ready, q.size() < DEPTH);
    check_head("done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [C_W-1:0] d5;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.mac_finish = 1'b0;
    bus.mac_o      = '0;
    bus.res_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", bus.mac_en, 0);
    chk("rst_rdy", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_c", bus.mac_c, 0);
    check_head("rst");
    rst = 1'b1;
    step();
    step();

    // single op: finish three cycles after the en pulse
    run_op(16'd1234, 2, 16'h04D2, 1'b0, 1'b0);
    pop_one("single");

    run_op(C_W'($urandom), -1, '0, 1'b0, 1'b0);
    pop_one("timeout");

    run_op(C_W'($urandom), TO - 1, 16'd7, 1'b0, 1'b0);
    pop_one("lastcyc");

    // stray finish in IDLE, then in LAUNCH
    bus.mac_finish = 1'b1;
    bus.mac_o      = 16'hBEEF;
    step();
    bus.mac_finish = 1'b0;
    step();
    chk("stray_idle_valid", bus.res_valid, 0);
    run_op(C_W'($urandom), 1, 16'h55AA, 1'b1, 1'b0);
    pop_one("stray");
    check_head("stray_empty");

    // FIFO full with back-pressure
    for (int i = 1; i <= 4; i++) begin
      run_op(C_W'($urandom), int'($urandom_range(0, 3)), O_W'(i), 1'b0, 1'b0);
    end
    d5 = C_W'($urandom);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_rdy", bus.cmd_ready, 0);
      chk("full_en", bus.mac_en, 0);
    end
    pop_one("full_pop");
    run_op(d5, 0, 16'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop_one("drain_full");
    check_head("full_empty");

    // simultaneous push and pop
    run_op(C_W'($urandom), 0, 16'h1111, 1'b0, 1'b0);
    run_op(C_W'($urandom), 2, 16'h2222, 1'b0, 1'b1);
    pop_one("pushpop");

    for (int i = 0; i < 40; i++) begin
      if (q.size() == DEPTH || (q.size() != 0 && ($urandom % 3) == 0)) pop_one("rnd_pop");
      run_op(C_W'($urandom), int'($urandom_range(0, 10)), O_W'($urandom),
             1'($urandom), 1'($urandom));
    end
    while (q.size() != 0) pop_one("rnd_drain");

    // drive err_cnt into saturation
    for (int i = 0; i < 260; i++) begin
      run_op(C_W'($urandom), -1, '0, 1'b0, 1'b1);
    end
    while (q.size() != 0) pop_one("sat_drain");

    // reset while in WAIT with two entries queued
    run_op(C_W'($urandom), 0, 16'hA001, 1'b0, 1'b0);
    run_op(C_W'($urandom), 1, 16'hA002, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = C_W'($urandom);
    step();
    bus.cmd_valid = 1'b0;
    chk("rw_launch_en", bus.mac_en, 1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    q.delete();
    err_m = 0;
    chk("rw_en", bus.mac_en, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_rdy", bus.cmd_ready, 0);
    check_head("rw");
    step();
    rst = 1'b1;
    bus.mac_finish = 1'b1;
    bus.mac_o      = 16'hDEAD;
    step();
    bus.mac_finish = 1'b0;
    step();
    check_head("rw_late_fin");

    // reset during LAUNCH drops mac_en without waiting for a clock
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = C_W'($urandom);
    step();
    bus.cmd_valid = 1'b0;
    chk("rl_en_pre", bus.mac_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("rl_en_async", bus.mac_en, 0);
    step();
    rst = 1'b1;
    step();
    step();

    run_op(C_W'($urandom), 3, 16'h7E57, 1'b0, 1'b0);
    pop_one("final");
    check_head("final_empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
Name: mac_driver

Overview:
- Initiator-side sequencer for the mac block.
- Accepts operand words on a valid/ready command port, drives mac c/en, waits for mac finish, then captures mac o.
- Returns results, plus a timeout error flag, through a 4-entry result FIFO on a valid/ready port.
- Sits between the system controller and the mac instance. It replaces the constant c/en tie-offs currently used around mac.

Parameters:
- C_W, 16, width of operand word driven on mac c.
- O_W, 16, width of mac result o.
- TIMEOUT, 255, maximum cycles to wait for finish after launch; must be 1..2^CNT_W-1.
- CNT_W, 8, width of timeout counter and error counter.
- DEPTH, 4, result FIFO entries; must be a power of 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- cmd_valid  in  1  operand word on cmd_data is valid.
- cmd_ready  out  1  driver can accept an operand this cycle.
- cmd_data  in  C_W  operand to send to mac.
- mac_c  out  C_W  operand to mac c; held stable from launch until completion.
- mac_en  out  1  one-cycle start pulse to mac en.
- mac_finish  in  1  mac completion strobe.
- mac_o  in  O_W  mac result; sampled in the cycle mac_finish is high.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer takes FIFO head.
- res_data  out  O_W  FIFO head result; 0 for a timeout entry.
- res_err  out  1  FIFO head is a timeout entry.
- busy  out  1  high in LAUNCH and WAIT.
- err_cnt  out  CNT_W  saturating count of timeouts since reset.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including cmd_ready=0 during reset; FIFO empty; counters 0.
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE:
  - cmd_ready = (fifo_count < DEPTH).
  - On cmd_valid && cmd_ready: register cmd_data into mac_c, go to LAUNCH.
  - mac_c keeps its previous value otherwise.
- LAUNCH:
  - mac_en = 1 for exactly this one cycle; cmd_ready = 0; wait counter cleared.
  - Next state is WAIT unconditionally.
  - mac_finish in this cycle is ignored.
- WAIT:
  - mac_en = 0; cmd_ready = 0; wait counter increments each cycle.
  - If mac_finish = 1: push {err=0, mac_o}, go to IDLE. Finish takes priority over timeout in the same cycle.
  - Else if counter == TIMEOUT-1: push {err=1, data=0}, increment err_cnt (saturating at all ones), go to IDLE.
- mac_finish in IDLE is ignored; no push occurs.
- Latency, for a command accepted at edge T:
  - mac_en high in cycle T+1.
  - Earliest honoured finish is in cycle T+2.
  - res_valid rises at T+3 if the FIFO was empty.
  - Timeout entry appears TIMEOUT cycles after WAIT entry.
- Only one operation is ever in flight. A command is accepted only when FIFO space exists, so a push can never overflow.
- FIFO:
  - Push on completion; pop on res_valid && res_ready.
  - Simultaneous push and pop leaves the count unchanged and data ordering is preserved.
  - res_data/res_err show the head entry; they are 0 when empty.
  - FIFO full holds cmd_ready low; it rises the cycle after a pop.
- Back-to-back: a new command may be accepted in the first IDLE cycle after completion, giving a minimum issue interval of 3 cycles.
- Reset asserted mid-operation:
  - Immediate abort; mac_en drops asynchronously.
  - FIFO contents are discarded.
  - A finish arriving after reset release is ignored, since the driver is in IDLE.

Test Plan:
- Single op: cmd_data=1234 with a mac model that asserts finish 3 cycles after en with o=0x04D2 -> exactly one mac_en pulse, mac_c=1234 held through WAIT, then res_valid=1, res_data=0x04D2, res_err=0.
- Timeout: TIMEOUT=8, mac never finishes -> exactly 8 WAIT cycles, then entry res_err=1, res_data=0, err_cnt=1, state returns to IDLE.
- FIFO full/backpressure: res_ready=0, issue 5 commands with o=1..5 -> 4 entries stored, cmd_ready=0 during the 5th. Then pop one -> cmd_ready=1, 5th completes, pops return 2,3,4,5 in order.
- Finish on the last timeout cycle: finish asserted with counter == TIMEOUT-1, o=7 -> res_err=0, res_data=7, err_cnt unchanged.
- Stray finish: mac_finish pulsed in IDLE and in LAUNCH -> no push; a subsequent finish in WAIT pushes exactly one entry.
- Reset mid-WAIT: rst low during WAIT with 2 entries in FIFO -> mac_en=0, res_valid=0, err_cnt=0. A finish arriving after reset release produces no entry.
